// File: rtl/fp_norm_round_pipe_if.sv
// rtl/fp_norm_round_pipe_if.sv - operand/result handshake bundle for fp_norm_round_pipe
interface fp_norm_round_pipe_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [FRAC_W+3:0] in_mant;
  logic [2:0]        in_frm;
  logic              in_ovf;
  logic              in_unf;
  logic              in_inv;
  logic              in_dz;
  logic              in_flip;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_result;
  logic [4:0]        out_flags;

  // Environment side: produces operands, consumes results
  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_frm,
    output in_ovf, in_unf, in_inv, in_dz, in_flip, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  // Pipeline side
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_frm,
    input  in_ovf, in_unf, in_inv, in_dz, in_flip, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_norm_round_pipe.sv
// rtl/fp_norm_round_pipe.sv - two-stage FP normalize (S1) and round/pack (S2) pipeline
module fp_norm_round_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                CLK,
  input  logic                nRST,
  fp_norm_round_pipe_if.slave bus
);
  localparam int W    = 1 + EXP_W + FRAC_W;
  localparam int XW   = EXP_W + 2;        // signed exponent intermediate width
  localparam int FW   = FRAC_W + 2;       // hidden..guard field scanned for leading zeros
  localparam int LZ_W = $clog2(FW + 1);
  localparam logic signed [XW-1:0] ONE_X    = XW'(1);
  localparam logic signed [XW-1:0] EMAX_X   = XW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [EXP_W-1:0]     EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};

  // mant holds {hidden, fraction, guard, sticky} after normalization
  typedef struct packed {
    logic              sign;
    logic              flip;
    logic [XW-1:0]     exp;
    logic [FRAC_W+2:0] mant;
    logic [2:0]        frm;
    logic              ovf;
    logic              unf;
    logic              inv;
    logic              dz;
    logic              zero;
    logic              flush;
  } s1_t;

  s1_t                  n_s1;
  s1_t                  s1_q, s1_d;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [W-1:0]         s2_result_q, s2_result_d;
  logic [4:0]           s2_flags_q, s2_flags_d;
  logic                 s2_adv;
  logic                 in_ready;

  logic [FW-1:0]        field;
  logic [LZ_W-1:0]      lz;
  logic signed [XW-1:0] lz_x;
  logic signed [XW-1:0] exp_x;

  logic                 sgn, grd, stk, lsb, inexact, frm_bad, inc, to_max, ovf_any;
  logic [FRAC_W:0]      sum;
  logic signed [XW-1:0] exp_r;
  logic [W-1:0]         r_result;
  logic [4:0]           r_flags;

  // S1 datapath: carry right-shift, leading-zero left-shift, zero and underflow detect
  always_comb begin
    field = bus.in_mant[FRAC_W+2:1];
    exp_x = XW'(bus.in_exp);
    lz    = LZ_W'(FW);
    for (int i = 0; i < FW; i++) begin
      if (field[i]) lz = LZ_W'(FW - 1 - i);
    end
    lz_x       = XW'(lz);
    n_s1       = '0;
    n_s1.sign  = bus.in_sign;
    n_s1.flip  = bus.in_flip;
    n_s1.frm   = bus.in_frm;
    n_s1.ovf   = bus.in_ovf;
    n_s1.unf   = bus.in_unf;
    n_s1.inv   = bus.in_inv;
    n_s1.dz    = bus.in_dz;
    n_s1.zero  = (bus.in_mant == '0);
    if (bus.in_mant[FRAC_W+3]) begin
      n_s1.mant = {bus.in_mant[FRAC_W+3:2], bus.in_mant[1] | bus.in_mant[0]};
      n_s1.exp  = exp_x + ONE_X;
    end else begin
      n_s1.mant  = {field << lz, bus.in_mant[0]};
      n_s1.exp   = exp_x - lz_x;
      n_s1.flush = !n_s1.zero && (lz_x >= exp_x);
    end
  end

  // Handshake: S1 refills whenever it is empty or moving into S2
  always_comb begin
    s2_adv     = !s2_valid_q || bus.out_ready;
    in_ready   = !s1_valid_q || s2_adv;
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) s1_d = n_s1;
    end
  end

  // S2 datapath: rounding increment, renormalize, overflow/exception packing
  always_comb begin
    sgn     = s1_q.sign ^ s1_q.flip;
    lsb     = s1_q.mant[2];
    grd     = s1_q.mant[1];
    stk     = s1_q.mant[0];
    inexact = grd | stk;
    frm_bad = (s1_q.frm > 3'd4);
    case (s1_q.frm)
      3'b001:  inc = 1'b0;
      3'b010:  inc = inexact & sgn;
      3'b011:  inc = inexact & ~sgn;
      3'b100:  inc = grd;
      default: inc = grd & (stk | lsb);
    endcase
    to_max = (s1_q.frm == 3'b001) || (s1_q.frm == 3'b010 && !sgn) ||
             (s1_q.frm == 3'b011 && sgn);
    sum    = {1'b0, s1_q.mant[FRAC_W+1:2]} + {{FRAC_W{1'b0}}, inc};
    exp_r  = $signed(s1_q.exp);
    if (sum[FRAC_W]) exp_r = exp_r + ONE_X;
    ovf_any = s1_q.ovf ||
              (!s1_q.unf && !s1_q.flush && !s1_q.zero && !s1_q.inv && (exp_r >= EMAX_X));

    r_result = {sgn, exp_r[EXP_W-1:0], sum[FRAC_W-1:0]};
    r_flags  = {frm_bad, s1_q.dz, 1'b0, 1'b0, inexact};
    if (s1_q.inv) begin
      r_result = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};
      r_flags  = {1'b1, s1_q.dz, 3'b000};
    end else if (ovf_any) begin
      r_result = to_max ? {sgn, EXP_MAXF, {FRAC_W{1'b1}}} : {sgn, EXP_ONES, {FRAC_W{1'b0}}};
      r_flags  = {frm_bad, s1_q.dz, 1'b1, 1'b0, 1'b1};
    end else if (s1_q.unf || s1_q.flush) begin
      r_result = {sgn, {(W-1){1'b0}}};
      r_flags  = {frm_bad, s1_q.dz, 1'b0, 1'b1, 1'b1};
    end else if (s1_q.zero) begin
      r_result = {sgn, {(W-1){1'b0}}};
      r_flags  = {frm_bad, s1_q.dz, 3'b000};
    end
  end

  // Output register loads only when empty or drained, so held results stay stable
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = r_result;
        s2_flags_d  = r_flags;
      end
    end
  end

  // Pipeline registers; reset discards anything in flight
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_flags_q  <= s2_flags_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_result = s2_result_q;
  assign bus.out_flags  = s2_flags_q;
endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// tb/tb_fp_norm_round_pipe.sv - scoreboard bench for fp_norm_round_pipe
module tb_fp_norm_round_pipe;
  logic CLK;
  logic nRST;
  int   total = 0;
  int   bad   = 0;
  logic [36:0] sb[$];
  bit   held;

  fp_norm_round_pipe_if #(.EXP_W(8), .FRAC_W(23)) bus ();

  fp_norm_round_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // xf = {inv, dz, ovf, unf, flip}; ef = {NV, DZ, OF, UF, NX}
  task automatic send(input logic sg, input logic [7:0] ex, input logic [26:0] mt,
                      input logic [2:0] fm, input logic [4:0] xf,
                      input logic [31:0] er, input logic [4:0] ef);
    bit ok;
    ok = 1'b0;
    bus.in_sign  = sg;
    bus.in_exp   = ex;
    bus.in_mant  = mt;
    bus.in_frm   = fm;
    bus.in_inv   = xf[4];
    bus.in_dz    = xf[3];
    bus.in_ovf   = xf[2];
    bus.in_unf   = xf[1];
    bus.in_flip  = xf[0];
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      ok = bus.in_ready;
      @(posedge CLK);
      #1;
    end
    if (ok) sb.push_back({er, ef});
    else check("accept_timeout", 64'(ok), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  // Output side: pop on each transfer, and a held result must equal the queue head
  always @(negedge CLK) begin
    if (!nRST) begin
      held = 1'b0;
    end else if (bus.out_valid) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        if (!bus.out_ready) begin
          if (held) check("hold_stable", 64'({bus.out_result, bus.out_flags}), 64'(sb[0]));
          held = 1'b1;
        end else begin
          check("result", 64'({bus.out_result, bus.out_flags}), 64'(sb.pop_front()));
          held = 1'b0;
        end
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    nRST          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.in_frm    = '0;
    bus.in_ovf    = 1'b0;
    bus.in_unf    = 1'b0;
    bus.in_inv    = 1'b0;
    bus.in_dz     = 1'b0;
    bus.in_flip   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_result", 64'(bus.out_result), 64'd0);
    check("rst_out_flags", 64'(bus.out_flags), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Latency: result visible after the second edge following presentation
    send(0, 8'd127, 27'h4000000, 3'd0, 5'b00000, 32'h40000000, 5'b00000);
    check("lat_not_early", 64'(bus.out_valid), 64'd0);
    @(posedge CLK);
    #1 check("lat_valid", 64'(bus.out_valid), 64'd1);

    send(0, 8'd127, 27'h3FFFFFE, 3'd0, 5'b00000, 32'h40000000, 5'b00001);
    send(0, 8'd127, 27'h3FFFFFE, 3'd1, 5'b00000, 32'h3FFFFFFF, 5'b00001);
    send(0, 8'd127, 27'h3FFFFFE, 3'd5, 5'b00000, 32'h40000000, 5'b10001);
    send(0, 8'd254, 27'h4000000, 3'd0, 5'b00000, 32'h7F800000, 5'b00101);
    send(0, 8'd254, 27'h4000000, 3'd1, 5'b00000, 32'h7F7FFFFF, 5'b00101);
    send(1, 8'd254, 27'h4000000, 3'd3, 5'b00000, 32'hFF7FFFFF, 5'b00101);
    send(0, 8'd253, 27'h4000000, 3'd0, 5'b00000, 32'h7F000000, 5'b00000);
    send(0, 8'd3,   27'h0100000, 3'd0, 5'b00000, 32'h00000000, 5'b00011);
    send(0, 8'd5,   27'h0100000, 3'd0, 5'b00000, 32'h00000000, 5'b00011);
    send(0, 8'd6,   27'h0100000, 3'd0, 5'b00000, 32'h00800000, 5'b00000);
    send(0, 8'd100, 27'h0100000, 3'd0, 5'b00000, 32'h2F800000, 5'b00000);
    send(0, 8'd127, 27'h2000000, 3'd0, 5'b10000, 32'h7FC00000, 5'b10000);
    send(1, 8'd127, 27'h2000000, 3'd0, 5'b11001, 32'h7FC00000, 5'b11000);
    send(1, 8'd50,  27'h0000000, 3'd0, 5'b01000, 32'h80000000, 5'b01000);
    send(1, 8'd127, 27'h2000000, 3'd0, 5'b00010, 32'h80000000, 5'b00011);
    send(0, 8'd10,  27'h2000000, 3'd0, 5'b00100, 32'h7F800000, 5'b00101);
    send(0, 8'd127, 27'h2000000, 3'd0, 5'b00001, 32'hBF800000, 5'b00000);
    send(0, 8'd127, 27'h2000002, 3'd4, 5'b00000, 32'h3F800001, 5'b00001);
    send(0, 8'd127, 27'h2000002, 3'd0, 5'b00000, 32'h3F800000, 5'b00001);
    send(1, 8'd127, 27'h2000002, 3'd2, 5'b00000, 32'hBF800001, 5'b00001);
    send(0, 8'd127, 27'h4000005, 3'd0, 5'b00000, 32'h40000001, 5'b00001);
    repeat (4) @(posedge CLK);
    #1;

    // Backpressure: out_ready low for 3 edges while streaming 4 operands
    send(0, 8'd120, 27'h2000000, 3'd0, 5'b00000, 32'h3C000000, 5'b00000);
    bus.out_ready = 1'b0;
    send(0, 8'd121, 27'h2000000, 3'd0, 5'b00000, 32'h3C800000, 5'b00000);
    bus.in_exp   = 8'd122;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge CLK);
      #1;
    end
    bus.out_ready = 1'b1;
    send(0, 8'd122, 27'h2000000, 3'd0, 5'b00000, 32'h3D000000, 5'b00000);
    send(0, 8'd123, 27'h2000000, 3'd0, 5'b00000, 32'h3D800000, 5'b00000);
    repeat (4) @(posedge CLK);
    #1;

    // Reset with two operands in flight
    bus.out_ready = 1'b0;
    send(0, 8'd100, 27'h2000000, 3'd0, 5'b00000, 32'h32000000, 5'b00000);
    send(0, 8'd101, 27'h2000000, 3'd0, 5'b00000, 32'h32800000, 5'b00000);
    #2 nRST = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_out_result", 64'(bus.out_result), 64'd0);
    check("arst_out_flags", 64'(bus.out_flags), 64'd0);
    sb.delete();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    bus.out_ready = 1'b1;
    check("rel_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge CLK);
    #1 check("rel_no_stale", 64'(bus.out_valid), 64'd0);
    send(0, 8'd124, 27'h2000000, 3'd0, 5'b00000, 32'h3E000000, 5'b00000);

    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge CLK);
    @(posedge CLK);
    #1 check("drain", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_norm_round_pipe.md
FP_NORM_ROUND_PIPE -- requirements
Module: fp_norm_round_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter FRAC_W, default 23, stored-fraction width; result width W = 1+EXP_W+FRAC_W.
REQ-003 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream operand valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operand this cycle.
REQ-007 SHALL have port in_sign  input  1  sign of unnormalized result.
REQ-008 SHALL have port in_exp  input  EXP_W  biased exponent before normalization.
REQ-009 SHALL have port in_mant  input  FRAC_W+4  {carry, hidden, fraction, guard, sticky}.
REQ-010 SHALL have port in_frm  input  3  rounding mode.
REQ-011 SHALL have port in_ovf, in_unf, in_inv, in_dz  input  1 each  upstream exception flags.
REQ-012 SHALL have port in_flip  input  1  invert final sign (both-negative subtract).
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts result.
REQ-015 SHALL have port out_result  output  W  {sign, exponent, fraction}.
REQ-016 SHALL have port out_flags  output  5  {NV, DZ, OF, UF, NX}.

Function
REQ-017 SHALL be a two-stage pipeline: S1 normalize, S2 round/pack; latency 2 cycles from accepted input to out_valid when unstalled.
REQ-018 SHALL transfer on valid&ready at each boundary; in_ready = !S1_valid | S1 advancing; S1 advances when !S2_valid | out_ready; one result per cycle sustained.
REQ-019 SHALL hold out_result/out_flags stable while out_valid & !out_ready; no drop, no duplication, order preserved.
REQ-020 S1: if carry=1, SHALL shift mantissa right 1, OR shifted-out bit into sticky, exponent +1.
REQ-021 S1: if carry=0 and hidden=0, SHALL left-shift by leading-zero count L (priority encoder over hidden..guard), exponent -L.
REQ-022 S1: if mantissa all zero, SHALL produce exact zero of in_sign, no flags (except NV/DZ passthrough).
REQ-023 S1: if L >= in_exp (unsigned, EXP_W+1-bit compare), SHALL flush to signed zero, set UF and NX.
REQ-024 S2 SHALL round per in_frm: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 SHALL round as RNE and set NV.
REQ-025 NX SHALL be set whenever guard|sticky is nonzero after S1.
REQ-026 Rounding carry out of the fraction SHALL renormalize: fraction 0, exponent +1.
REQ-027 Final exponent >= all-ones (2^EXP_W-1) or in_ovf SHALL set OF and NX; result infinity, except max-finite for RTZ, RDN with sign 0, RUP with sign 1.
REQ-028 in_unf SHALL force signed zero with UF and NX.
REQ-029 in_inv SHALL force canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0), flags NV only plus DZ passthrough; priority inv > ovf > unf > normal.
REQ-030 in_flip SHALL invert the packed sign bit, not applied to the canonical NaN.
REQ-031 in_dz SHALL pass to DZ unchanged.
REQ-032 Exponent arithmetic SHALL use EXP_W+2-bit signed intermediates; no wrap-around.

Reset
REQ-033 nRST low SHALL asynchronously clear S1_valid, S2_valid, out_valid=0, out_result=0, out_flags=0, in_ready=1 after release.
REQ-034 In-flight operands at reset assertion SHALL be discarded; first output after release SHALL come from a post-reset input.

Verification (EXP_W=8, FRAC_W=23)
REQ-035 exp=127, mant carry=1 rest 0, RNE -> out_result 0x40000000, flags 0, out_valid exactly 2 cycles after accept.
REQ-036 exp=127, hidden=1, fraction all ones, guard=1, sticky=0: RNE -> 0x40000000 NX; RTZ -> 0x3FFFFFFF NX; frm=101 -> 0x40000000 flags NV|NX.
REQ-037 exp=254, carry=1: RNE -> 0x7F800000 OF|NX; RTZ -> 0x7F7FFFFF OF|NX; sign=1 RUP -> 0xFF7FFFFF.
REQ-038 exp=3, hidden=0, L=5 -> 0x00000000 UF|NX; in_inv=1 -> 0x7FC00000 NV.
REQ-039 Stream 4 operands back-to-back, out_ready low 3 cycles -> in_ready low after 2 held, outputs stable, all 4 emerge in order.
REQ-040 Assert nRST with 2 operands in flight -> out_valid 0 immediately, no stale output after release.
